pc_fetch_unit: RTL and testbench
================================

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 The block SHALL have parameter PC_W, default 12, meaning the program counter and instruction address width.
REQ-002 The block SHALL have parameter INSTR_W, default 32, meaning the instruction word width.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1, SHALL be the reset: synchronous, active-high.
REQ-006 Port start, input, 1, SHALL be a single-cycle pulse that begins program execution at address 0.
REQ-007 Port clken_PC, input, 1, SHALL be the PC advance enable from the PC control logic.
REQ-008 Port load_PC, input, 1, SHALL be the branch-taken request: load load_value_PC.
REQ-009 Port incr_PC, input, 1, SHALL be the sequential-advance request: PC+1.
REQ-010 Port load_value_PC, input, PC_W, SHALL be the branch target.
REQ-011 Port imem_en, output, 1, SHALL be the instruction memory read enable.
REQ-012 Port imem_addr, output, PC_W, SHALL be the instruction memory read address.
REQ-013 Port imem_rdata, input, INSTR_W, SHALL be the read data, valid exactly one cycle after imem_en.
REQ-014 Port pc, output, PC_W, SHALL be the current PC.
REQ-015 Port instr, output, INSTR_W, SHALL be the latched current instruction.
REQ-016 Port instr_valid, output, 1, SHALL indicate that instr and the decode outputs are valid.
REQ-017 Ports is_not_vect, is_bne, is_vstreamout (each output, 1) and branch_immediate (output, 12) SHALL be the decode fields fed to the PC control logic.
REQ-018 Port done, output, 1, SHALL indicate that the program has halted.

Function
REQ-019 The FSM SHALL have exactly four states: IDLE, FETCH, RUN, HALTED.
REQ-020 In IDLE, a sampled start SHALL set pc<=0 and move to FETCH; all other inputs SHALL be ignored.
REQ-021 In FETCH, the block SHALL assert imem_en=1 with imem_addr=pc for exactly one cycle, then move to RUN; imem_en SHALL be 0 in every other state.
REQ-022 On entry to RUN, instr SHALL capture imem_rdata and instr_valid SHALL be 1 for the whole RUN stay.
REQ-023 Decode SHALL be taken from the latched instr: opcode=instr[31:28]; is_not_vect=!instr[31]; is_bne=(opcode==4'h5); is_vstreamout=(opcode==4'hC); branch_immediate=instr[11:0]; HALT opcode=4'hF.
REQ-024 When instr_valid=0, all decode outputs SHALL be driven 0.
REQ-025 In RUN with opcode HALT, the block SHALL move to HALTED on the next edge and ignore clken_PC.
REQ-026 In RUN with clken_PC=1 and load_PC=1, the block SHALL set pc<=load_value_PC, clear instr_valid and move to FETCH; load has priority over incr.
REQ-027 In RUN with clken_PC=1, load_PC=0 and incr_PC=1, the block SHALL set pc<=pc+1 modulo 2^PC_W (4095 wraps to 0), clear instr_valid and move to FETCH.
REQ-028 In RUN with clken_PC=0, or with clken_PC=1 and neither load_PC nor incr_PC set, the block SHALL hold pc, instr and state.
REQ-029 Latency SHALL be: start or advance sampled at cycle n -> imem_en at n+1 -> instr_valid at n+2.
REQ-030 In HALTED, done SHALL be 1 and pc and instr SHALL be held; a sampled start SHALL set pc<=0, clear done and move to FETCH.
REQ-031 start SHALL be ignored in FETCH and RUN.

Reset
REQ-032 A sampled rst SHALL, in any state including mid-FETCH, force state=IDLE, pc=0, instr=0, instr_valid=0, done=0, imem_en=0 and imem_addr=0.
REQ-033 rst SHALL take priority over all other inputs, and any imem_rdata returning after reset SHALL be discarded.

Verification
REQ-034 Sequential fetch: start at cycle 0, with imem[0]=0x00000000 and clken_PC=incr_PC=1 held -> imem_en at cycle 1 with imem_addr=0, instr_valid at cycle 2, and imem_addr=1 at cycle 3.
REQ-035 Branch taken: RUN with imem[3]=0x50000010 -> is_bne=1, is_not_vect=1, branch_immediate=0x010; then clken_PC=load_PC=incr_PC=1 -> pc=0x010 and next imem_addr=0x010.
REQ-036 Stall: RUN with imem[2] a vector opcode (instr[31]=1) and clken_PC=0 for 5 cycles -> pc=2, instr_valid=1 and imem_en=0 throughout; clken_PC=1 with incr_PC=1 -> pc=3.
REQ-037 Wrap and halt: pc=4095, incr -> pc=0; imem[0]=0xF0000000 -> done=1 one cycle after instr_valid, and clken_PC=1 has no effect; start -> done=0 and pc=0.
REQ-038 Reset mid-operation: rst asserted during FETCH -> next cycle state=IDLE, all outputs 0, and the late imem_rdata is not captured.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and instruction fetch front end.
// Fetches one instruction per PC advance from a synchronous instruction
// memory, latches it, and decodes the fields used by the PC control logic.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   start                one-cycle pulse, begins execution at address 0
//   clken_PC             PC advance enable
//   load_PC, incr_PC     branch-taken / sequential advance requests
//   load_value_PC        branch target
//   imem_en, imem_addr   instruction memory read request
//   imem_rdata           read data, valid the cycle after imem_en
//   pc, instr            current PC and current instruction
//   instr_valid          instr and the decode outputs are valid
//   is_not_vect, is_bne, is_vstreamout, branch_immediate  decode fields
//   done                 program has halted
module pc_fetch_unit #(
    parameter int PC_W    = 12,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               clken_PC,
    input  logic               load_PC,
    input  logic               incr_PC,
    input  logic [PC_W-1:0]    load_value_PC,
    output logic               imem_en,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [PC_W-1:0]    pc,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    output logic               is_not_vect,
    output logic               is_bne,
    output logic               is_vstreamout,
    output logic [11:0]        branch_immediate,
    output logic               done
);

    localparam logic [3:0] OP_BNE  = 4'h5;
    localparam logic [3:0] OP_VSO  = 4'hC;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        RUN,
        HALTED
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PC_W-1:0]    r_pc;
    logic [PC_W-1:0]    w_pc_nxt;
    logic [INSTR_W-1:0] r_instr;
    logic [INSTR_W-1:0] w_instr_nxt;
    logic               r_first;
    logic               w_first_nxt;

    logic [INSTR_W-1:0] w_instr;
    logic               w_valid;
    logic [3:0]         w_opcode;

    // The memory answers in the first RUN cycle, so that cycle forwards
    // the read data directly; it is held in r_instr from then on.
    assign w_instr  = (r_state == RUN && r_first) ? imem_rdata : r_instr;
    assign w_valid  = (r_state == RUN);
    assign w_opcode = w_instr[31:28];

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_instr_nxt = r_instr;
        w_first_nxt = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_pc_nxt    = '0;
                    w_state_nxt = FETCH;
                end
            end
            FETCH: begin
                w_state_nxt = RUN;
                w_first_nxt = 1'b1;
            end
            RUN: begin
                w_instr_nxt = w_instr;
                if (w_opcode == OP_HALT) begin
                    w_state_nxt = HALTED;
                end else if (clken_PC && load_PC) begin
                    w_pc_nxt    = load_value_PC;
                    w_state_nxt = FETCH;
                end else if (clken_PC && incr_PC) begin
                    w_pc_nxt    = r_pc + PC_W'(1);
                    w_state_nxt = FETCH;
                end
            end
            HALTED: begin
                if (start) begin
                    w_pc_nxt    = '0;
                    w_state_nxt = FETCH;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_pc    <= '0;
            r_instr <= '0;
            r_first <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_instr <= w_instr_nxt;
            r_first <= w_first_nxt;
        end
    end

    assign imem_en          = (r_state == FETCH);
    assign imem_addr        = r_pc;
    assign pc               = r_pc;
    assign instr            = w_instr;
    assign instr_valid      = w_valid;
    assign done             = (r_state == HALTED);
    assign is_not_vect      = w_valid & ~w_instr[31];
    assign is_bne           = w_valid & (w_opcode == OP_BNE);
    assign is_vstreamout    = w_valid & (w_opcode == OP_VSO);
    assign branch_immediate = w_valid ? w_instr[11:0] : 12'h000;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed table-driven bench for pc_fetch_unit.
// Synchronous instruction memory model; per-cycle output bundle checks.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        clken_PC;
    logic        load_PC;
    logic        incr_PC;
    logic [11:0] load_value_PC;
    logic        imem_en;
    logic [11:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic [11:0] pc;
    logic [31:0] instr;
    logic        instr_valid;
    logic        is_not_vect;
    logic        is_bne;
    logic        is_vstreamout;
    logic [11:0] branch_immediate;
    logic        done;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] imem [0:4095];

    pc_fetch_unit #(.PC_W(12), .INSTR_W(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .clken_PC         (clken_PC),
        .load_PC          (load_PC),
        .incr_PC          (incr_PC),
        .load_value_PC    (load_value_PC),
        .imem_en          (imem_en),
        .imem_addr        (imem_addr),
        .imem_rdata       (imem_rdata),
        .pc               (pc),
        .instr            (instr),
        .instr_valid      (instr_valid),
        .is_not_vect      (is_not_vect),
        .is_bne           (is_bne),
        .is_vstreamout    (is_vstreamout),
        .branch_immediate (branch_immediate),
        .done             (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_en === 1'b1) imem_rdata <= imem[imem_addr];
    end

    typedef struct {
        logic        rst, st, ck, ld, inc;
        logic [11:0] lv;
        logic [11:0] pc;
        logic        en;
        logic [11:0] addr;
        logic        iv;
        logic [31:0] ins;
        logic        dn, nv, bne, vso;
        logic [11:0] imm;
    } vec_t;

    function automatic vec_t mk(
        input logic rs, input logic st, input logic ck,
        input logic ld, input logic inc, input logic [11:0] lv,
        input logic [11:0] p, input logic en, input logic [11:0] a,
        input logic iv, input logic [31:0] ins, input logic dn,
        input logic nv, input logic bne, input logic vso,
        input logic [11:0] imm);
        vec_t v;
        v.rst = rs; v.st = st; v.ck = ck; v.ld = ld; v.inc = inc;
        v.lv = lv; v.pc = p; v.en = en; v.addr = a; v.iv = iv;
        v.ins = ins; v.dn = dn; v.nv = nv; v.bne = bne; v.vso = vso;
        v.imm = imm;
        return v;
    endfunction

    task automatic step(input vec_t v, input string name);
        rst           = v.rst;
        start         = v.st;
        clken_PC      = v.ck;
        load_PC       = v.ld;
        incr_PC       = v.inc;
        load_value_PC = v.lv;
        @(posedge clk);
        #1;
        n_cmp++;
        if (pc !== v.pc || imem_en !== v.en || imem_addr !== v.addr ||
            instr_valid !== v.iv || instr !== v.ins || done !== v.dn ||
            is_not_vect !== v.nv || is_bne !== v.bne ||
            is_vstreamout !== v.vso || branch_immediate !== v.imm) begin
            n_bad++;
            $display("FAIL %s: got pc=%h en=%b addr=%h iv=%b instr=%h done=%b nv=%b bne=%b vso=%b imm=%h ; want pc=%h en=%b addr=%h iv=%b instr=%h done=%b nv=%b bne=%b vso=%b imm=%h",
                name, pc, imem_en, imem_addr, instr_valid, instr, done,
                is_not_vect, is_bne, is_vstreamout, branch_immediate,
                v.pc, v.en, v.addr, v.iv, v.ins, v.dn, v.nv, v.bne, v.vso,
                v.imm);
        end
    endtask

    vec_t tbl[$];

    initial begin
        for (int i = 0; i < 4096; i++) imem[i] = 32'h0;
        imem[0]      = 32'h0000_0000;
        imem[1]      = 32'h1234_5678;
        imem[2]      = 32'h8000_0ABC;
        imem[3]      = 32'h5000_0010;
        imem[12'h010] = 32'hC000_0123;
        imem[12'hFFF] = 32'h0000_0001;

        // sequential fetch from start
        tbl.push_back(mk(0,1,1,0,1,0, 0,1,0,0,32'h0,0, 0,0,0,0));
        tbl.push_back(mk(0,0,1,0,1,0, 0,0,0,1,32'h0,0, 1,0,0,0));
        tbl.push_back(mk(0,0,1,0,1,0, 1,1,1,0,32'h0,0, 0,0,0,0));
        tbl.push_back(mk(0,0,1,0,1,0, 1,0,1,1,32'h12345678,0, 1,0,0,12'h678));
        tbl.push_back(mk(0,0,1,0,1,0, 2,1,2,0,32'h12345678,0, 0,0,0,0));
        // vector instr at 2, stall with clken_PC=0 (start/load ignored)
        tbl.push_back(mk(0,1,0,0,0,0, 2,0,2,1,32'h80000ABC,0, 0,0,0,12'hABC));
        tbl.push_back(mk(0,0,0,0,1,0, 2,0,2,1,32'h80000ABC,0, 0,0,0,12'hABC));
        tbl.push_back(mk(0,1,0,0,1,0, 2,0,2,1,32'h80000ABC,0, 0,0,0,12'hABC));
        tbl.push_back(mk(0,0,0,1,1,12'h055, 2,0,2,1,32'h80000ABC,0, 0,0,0,12'hABC));
        tbl.push_back(mk(0,0,0,0,1,0, 2,0,2,1,32'h80000ABC,0, 0,0,0,12'hABC));
        tbl.push_back(mk(0,0,0,0,0,0, 2,0,2,1,32'h80000ABC,0, 0,0,0,12'hABC));
        tbl.push_back(mk(0,0,1,0,1,0, 3,1,3,0,32'h80000ABC,0, 0,0,0,0));
        // bne at 3, branch taken with load and incr both set
        tbl.push_back(mk(0,0,0,0,0,0, 3,0,3,1,32'h50000010,0, 1,1,0,12'h010));
        tbl.push_back(mk(0,0,1,1,1,12'h010, 12'h010,1,12'h010,0,32'h50000010,0, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0, 12'h010,0,12'h010,1,32'hC0000123,0, 0,0,1,12'h123));
        // branch to the top address
        tbl.push_back(mk(0,0,1,1,0,12'hFFF, 12'hFFF,1,12'hFFF,0,32'hC0000123,0, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0, 12'hFFF,0,12'hFFF,1,32'h00000001,0, 1,0,0,12'h001));
        // clken_PC=1 with no request holds
        tbl.push_back(mk(0,0,1,0,0,0, 12'hFFF,0,12'hFFF,1,32'h00000001,0, 1,0,0,12'h001));

        rst = 1'b1; start = 1'b0; clken_PC = 1'b0;
        load_PC = 1'b0; incr_PC = 1'b0; load_value_PC = 12'h0;
        @(posedge clk);
        step(mk(1,0,0,0,0,0, 0,0,0,0,32'h0,0, 0,0,0,0), "reset");
        step(mk(0,0,1,1,1,12'h0AA, 0,0,0,0,32'h0,0, 0,0,0,0), "idle_ignore");

        foreach (tbl[i]) step(tbl[i], $sformatf("row%0d", i));

        // wrap 4095 -> 0, then HALT at 0
        imem[0] = 32'hF000_0000;
        step(mk(0,0,1,0,1,0, 0,1,0,0,32'h00000001,0, 0,0,0,0), "wrap");
        step(mk(0,0,1,0,1,0, 0,0,0,1,32'hF0000000,0, 0,0,0,0), "halt_run");
        step(mk(0,0,1,0,1,0, 0,0,0,0,32'hF0000000,1, 0,0,0,0), "halted");
        step(mk(0,0,1,1,1,12'h123, 0,0,0,0,32'hF0000000,1, 0,0,0,0), "halted_hold");
        // restart from HALTED
        imem[0] = 32'h0000_0000;
        step(mk(0,1,0,0,0,0, 0,1,0,0,32'hF0000000,0, 0,0,0,0), "restart");
        step(mk(0,0,0,0,0,0, 0,0,0,1,32'h0,0, 1,0,0,0), "restart_run");
        step(mk(0,0,1,0,1,0, 1,1,1,0,32'h0,0, 0,0,0,0), "fetch1");
        // reset mid-FETCH; the read of imem[1] returns afterwards
        step(mk(1,1,1,0,1,0, 0,0,0,0,32'h0,0, 0,0,0,0), "rst_fetch");
        step(mk(0,0,1,1,1,12'h005, 0,0,0,0,32'h0,0, 0,0,0,0), "late_data");
        step(mk(0,1,0,0,0,0, 0,1,0,0,32'h0,0, 0,0,0,0), "start_again");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
